// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int SW = (D_STREAK < 1) ? 1 : $clog2(D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);

  state_t        state;
  logic [SW-1:0] streak;
  logic          i_live;
  logic          d_live;
  logic          grant_d;
  logic          grant_i;

  // A requester still showing its ack pulse is masked so a held request is
  // not re-granted on the same edge; data wins ties until the streak limit.
  always_comb begin
    i_live  = i_req & ~i_ack;
    d_live  = d_req & ~d_ack;
    grant_d = d_live & (~i_live | (streak < STREAK_MAX));
    grant_i = i_live & ~grant_d;
  end

  // Arbitration FSM with registered memory strobes, acks and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_live) begin
            streak <= '0;
          end
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            owner     <= 1'b1;
            busy      <= 1'b1;
            if (i_live) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            owner     <= 1'b0;
            busy      <= 1'b1;
            streak    <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            d_ack   <= 1'b1;
            d_rdata <= mem_we ? '0 : mem_rdata;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int DS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        owner;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK(DS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Environment memory (written from the DUT's strobes) and the model's
  // shadow copy (written from the requesters' own store intents).
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  logic [31:0] junk;

  assign mem_rdata = (mem_req && mem_ready) ? mem[mem_addr[9:2]] : junk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  bit          m_busy, m_own, m_iack, m_dack;
  int          m_streak;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          m_we;

  // Grants observed on the DUT: owner at the rise of mem_req and its cycle
  bit dq_who[$];
  int dq_cyc[$];
  bit prev_mreq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_iack = 0; m_dack = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic check_all();
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
    chk("busy",    {31'd0, busy},    {31'd0, m_busy});
    chk("owner",   {31'd0, owner},   {31'd0, m_own});
    chk("i_ack",   {31'd0, i_ack},   {31'd0, m_iack});
    chk("d_ack",   {31'd0, d_ack},   {31'd0, m_dack});
    chk("mem_we",  {31'd0, mem_we},  {31'd0, m_we});
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_rdata",   i_rdata,   m_irdata);
    chk("d_rdata",   d_rdata,   m_drdata);
  endtask

  // One clock: predict the effect of the coming edge from the spec rules,
  // run the edge, then compare every output at the falling edge.
  task automatic step();
    bit mi, md, n_iack, n_dack;
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;
    junk = $urandom();
    n_iack = 0;
    n_dack = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        mi = i_req && !m_iack;
        md = d_req && !m_dack;
        if (md && (!mi || m_streak < DS)) begin
          m_streak = mi ? m_streak + 1 : 0;
          m_busy = 1; m_own = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        end else if (mi) begin
          m_streak = 0;
          m_busy = 1; m_own = 0; m_addr = i_addr; m_we = 0; m_wdata = '0;
        end else begin
          m_streak = 0;
        end
      end else if (mem_ready) begin
        m_busy = 0;
        if (m_own) begin
          n_dack = 1;
          if (m_we) begin
            shadow[m_addr[9:2]] = m_wdata;
            m_drdata = '0;
          end else begin
            m_drdata = shadow[m_addr[9:2]];
          end
        end else begin
          n_iack = 1;
          m_irdata = shadow[m_addr[9:2]];
        end
      end
      m_iack = n_iack;
      m_dack = n_dack;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
    if (mem_req && !prev_mreq) begin
      dq_who.push_back(owner);
      dq_cyc.push_back(cyc);
    end
    prev_mreq = mem_req;
  endtask

  initial begin
    int nd;
    bit got_i;
    for (int k = 0; k < 256; k++) begin
      mem[k]    = $urandom();
      shadow[k] = mem[k];
    end
    mem[8'h10]    = 32'h2008_0005;
    shadow[8'h10] = 32'h2008_0005;
    rst_n = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; mem_ready = 0; junk = '0; prev_mreq = 0;
    model_reset();

    // Reset state
    step();
    step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    rst_n = 1;

    // Single fetch, zero wait
    mem_ready = 1;
    i_req = 1; i_addr = 32'h0000_0040;
    step();
    chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h0000_0040);
    step();
    chk("fetch_ack", {31'd0, i_ack}, 32'd1);
    chk("fetch_rdata", i_rdata, 32'h2008_0005);
    i_req = 0;
    step();

    // Store with three wait cycles, then load back
    mem_ready = 0;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    step();
    chk("store_mem_we", {31'd0, mem_we}, 32'd1);
    chk("store_owner", {31'd0, owner}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("store_wait_req", {31'd0, mem_req}, 32'd1);
      chk("store_wait_noack", {31'd0, d_ack}, 32'd0);
    end
    mem_ready = 1;
    step();
    chk("store_ack", {31'd0, d_ack}, 32'd1);
    chk("store_rdata_zero", d_rdata, 32'd0);
    d_req = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 32'h100;
    step();
    step();
    chk("load_ack", {31'd0, d_ack}, 32'd1);
    chk("load_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 0;
    step();

    // Simultaneous requests: data first, fetch at the edge after d_ack
    dq_who.delete(); dq_cyc.delete();
    i_req = 1; i_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
    step();
    chk("sim_owner_d", {31'd0, owner}, 32'd1);
    step();
    chk("sim_dack", {31'd0, d_ack}, 32'd1);
    d_req = 0;
    step();
    chk("sim_owner_i", {31'd0, owner}, 32'd0);
    chk("sim_fetch_req", {31'd0, mem_req}, 32'd1);
    step();
    chk("sim_iack", {31'd0, i_ack}, 32'd1);
    i_req = 0;
    step();

    // Fetch forward progress with data held continuously
    dq_who.delete(); dq_cyc.delete();
    d_req = 1; d_we = 0; d_addr = 32'h20; i_req = 1; i_addr = 32'h24;
    for (int k = 0; k < 30 && !m_iack; k++) step();
    i_req = 0;
    nd = 0; got_i = 0;
    foreach (dq_who[k]) begin
      if (!got_i && dq_who[k]) nd++;
      if (!dq_who[k]) got_i = 1;
    end
    chk("starve_fetch_granted", {31'd0, got_i}, 32'd1);
    chk("starve_bound", {31'd0, nd <= DS}, 32'd1);
    for (int k = 0; k < 10 && (m_busy || d_req); k++) begin
      if (m_dack) d_req = 0;
      step();
    end
    d_req = 0;
    step();

    // Held fetch request through its ack: re-grant exactly three edges later
    dq_who.delete(); dq_cyc.delete();
    i_req = 1; i_addr = 32'h48;
    for (int k = 0; k < 7; k++) step();
    chk("mask_grants", dq_cyc.size(), 32'd3);
    if (dq_cyc.size() >= 2) chk("mask_gap", dq_cyc[1] - dq_cyc[0], 32'd3);
    for (int k = 0; k < 5 && !m_iack; k++) step();
    i_req = 0;
    step();

    // Asynchronous reset during a data access with memory stalled
    mem_ready = 0;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    step();
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    chk("async_rst_dack", {31'd0, d_ack}, 32'd0);
    model_reset();
    step();
    rst_n = 1;
    mem_ready = 1;
    step();
    chk("rst_regrant_req", {31'd0, mem_req}, 32'd1);
    chk("rst_regrant_addr", mem_addr, 32'h80);
    step();
    chk("rst_regrant_ack", {31'd0, d_ack}, 32'd1);
    d_req = 0;
    step();

    // Randomized traffic with random wait states
    for (int n = 0; n < 1500; n++) begin
      if (i_req) begin
        if (m_iack) begin
          if ($urandom_range(0, 2) == 0) i_addr = 32'($urandom_range(0, 255)) << 2;
          else i_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (d_req) begin
        if (m_dack) begin
          if ($urandom_range(0, 2) == 0) begin
            d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 255)) << 2;
            d_wdata = $urandom();
          end else begin
            d_req = 0;
          end
        end
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255)) << 2; d_wdata = $urandom();
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
